input_debouncer: RTL
====================

INPUT_DEBOUNCER -- requirements
Module: input_debouncer

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the number of synchroniser flops on in_i (legal range 2..4).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 16, meaning the consecutive stable synchronised cycles required to accept a new level (legal minimum 2).
REQ-003 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port in_i, input, 1 bit: raw asynchronous, bouncy input (switch or pin).
REQ-006 SHALL have port level_o, output, 1 bit: debounced registered level for downstream flops.
REQ-007 SHALL have port rise_o, output, 1 bit: one-cycle pulse when level_o goes 0->1.
REQ-008 SHALL have port fall_o, output, 1 bit: one-cycle pulse when level_o goes 1->0.
REQ-009 SHALL have port busy_o, output, 1 bit: high while a candidate level change is being qualified.

Function
REQ-010 SHALL pass in_i through SYNC_STAGES flops; the last stage is the synchronised value s.
REQ-011 SHALL implement the FSM states STABLE_LOW, WAIT_HIGH, STABLE_HIGH and WAIT_LOW.
REQ-012 In STABLE_LOW: if s=1, go to WAIT_HIGH and load cnt=1; otherwise hold.
REQ-013 In WAIT_HIGH:
- s=0: return to STABLE_LOW, cnt=0, no pulse.
- s=1 and cnt==DEBOUNCE_CYCLES-1: go to STABLE_HIGH, level_o<=1, rise_o<=1.
- Otherwise: cnt+1.
REQ-014 STABLE_HIGH and WAIT_LOW SHALL mirror REQ-012/013 with polarities inverted; acceptance sets level_o<=0 and fall_o<=1.
REQ-015 level_o SHALL change only after s has held the new value on exactly DEBOUNCE_CYCLES consecutive sampling edges.
REQ-016 Latency: with in_i stable from sampling edge E0, level_o SHALL update at edge E0+SYNC_STAGES+DEBOUNCE_CYCLES-1.
REQ-017 rise_o and fall_o SHALL be registered, high for exactly one cycle, coincident with the level_o change, and never high together.
REQ-018 busy_o SHALL equal (state==WAIT_HIGH or state==WAIT_LOW), decoded from registered state.
REQ-019 cnt SHALL be $clog2(DEBOUNCE_CYCLES+1) bits wide and SHALL never exceed DEBOUNCE_CYCLES-1; no wrap is reachable.
REQ-020 A bounce back to the old level during WAIT_* SHALL restart qualification from zero on the next departure.

Reset
REQ-021 Asserting rst SHALL immediately clear all sync flops, set state=STABLE_LOW and cnt=0, and drive level_o, rise_o, fall_o and busy_o to 0.
REQ-022 rst asserted mid-qualification SHALL abort it with no pulse.
REQ-023 After rst deasserts, in_i already high SHALL be qualified normally, producing rise_o once.

Configuration
REQ-024 Macro INPUT_DEBOUNCER_EDGE_EN SHALL control the edge pulses.
- Defined: rise_o and fall_o behave per REQ-013/014/017.
- Undefined: rise_o and fall_o are tied to constant 0, their pulse registers are not built, and level_o and busy_o behaviour is unchanged.

Structure
REQ-025 Package debounce_pkg SHALL hold the state enum typedef (deb_state_t) and the constants SYNC_STAGES_MIN=2 and DEBOUNCE_MIN=2.
REQ-026 Sub-module sync_chain (parameter STAGES, ports clk, rst, d, q) SHALL implement REQ-010 and be reusable elsewhere.
REQ-027 An elaboration-time check SHALL reject SYNC_STAGES<2 or DEBOUNCE_CYCLES<2.

Verification (SYNC_STAGES=2, DEBOUNCE_CYCLES=4 unless noted)
REQ-028 Clean rise: in_i 0->1 held from edge E0 -> level_o=1 and rise_o=1 at E0+5; rise_o=0 at E0+6; busy_o high for 3 cycles beforehand.
REQ-029 Glitch: in_i high for 3 cycles, then low -> level_o remains 0, no rise_o, busy_o high 3 cycles then 0.
REQ-030 Bounce: pattern 1,1,0,1,1,1,1 -> single rise_o, asserted 4 cycles after the final 0 is synchronised.
REQ-031 Fall: from level_o=1, in_i->0 held -> fall_o one cycle at E0+5, level_o=0.
REQ-032 Reset mid-WAIT_HIGH with cnt=2 -> all outputs 0 immediately; after release with in_i still 1, rise_o occurs 5 edges after the first post-reset sampling edge.
REQ-033 Build with INPUT_DEBOUNCER_EDGE_EN undefined and rerun REQ-028 -> level_o timing identical, rise_o/fall_o constantly 0.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and limits for the input debouncer.
package debounce_pkg;

    // Qualification FSM: two stable levels, each with a pending-change state.
    typedef enum logic [1:0] {
        StStableLow  = 2'd0,
        StWaitHigh   = 2'd1,
        StStableHigh = 2'd2,
        StWaitLow    = 2'd3
    } deb_state_t;

    localparam int unsigned SYNC_STAGES_MIN = 2;
    localparam int unsigned DEBOUNCE_MIN    = 2;

endpackage

// File: rtl/sync_chain.sv
// Generic multi-flop synchroniser for a single asynchronous bit.
// The last stage (q) is the only output meant for use in the clk domain.
module sync_chain #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_sync;

    // Shift the raw input through the chain; reset clears every stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], d};
        end
    end

    assign q = r_sync[STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Debouncer for a raw asynchronous input: synchronise, then accept a new level
// only after it has been seen on DEBOUNCE_CYCLES consecutive clock edges.
// Define INPUT_DEBOUNCER_EDGE_EN to build the rise_o/fall_o pulse registers;
// otherwise both pulses are tied low.
module input_debouncer
    import debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic in_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic busy_o
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_bad_sync
        $error("input_debouncer: SYNC_STAGES must be at least 2");
    end
    if (DEBOUNCE_CYCLES < DEBOUNCE_MIN) begin : g_bad_deb
        $error("input_debouncer: DEBOUNCE_CYCLES must be at least 2");
    end

    logic             w_s;
    deb_state_t       r_state;
    deb_state_t       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_level;
    logic             w_level_next;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (in_i),
        .q   (w_s)
    );

    // State, counter and debounced level registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StStableLow;
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_level <= w_level_next;
        end
    end

    // Next-state logic; the departure edge counts as the first stable sample,
    // so acceptance happens when the count has already reached DEBOUNCE_CYCLES-1.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_level_next = r_level;
        unique case (r_state)
            StStableLow: begin
                if (w_s) begin
                    w_state_next = StWaitHigh;
                    w_cnt_next   = CNT_ONE;
                end
            end
            StWaitHigh: begin
                if (!w_s) begin
                    w_state_next = StStableLow;
                    w_cnt_next   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_next = StStableHigh;
                    w_cnt_next   = '0;
                    w_level_next = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + CNT_ONE;
                end
            end
            StStableHigh: begin
                if (!w_s) begin
                    w_state_next = StWaitLow;
                    w_cnt_next   = CNT_ONE;
                end
            end
            StWaitLow: begin
                if (w_s) begin
                    w_state_next = StStableHigh;
                    w_cnt_next   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_next = StStableLow;
                    w_cnt_next   = '0;
                    w_level_next = 1'b0;
                end else begin
                    w_cnt_next = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_next = StStableLow;
                w_cnt_next   = '0;
                w_level_next = 1'b0;
            end
        endcase
    end

`ifdef INPUT_DEBOUNCER_EDGE_EN
    logic r_rise;
    logic r_fall;
    logic w_rise_next;
    logic w_fall_next;

    // A pulse fires on the same edge that the level register is updated.
    always_comb begin
        w_rise_next = (r_state == StWaitHigh) && (w_state_next == StStableHigh) && w_level_next;
        w_fall_next = (r_state == StWaitLow) && (w_state_next == StStableLow) && !w_level_next;
    end

    // Edge pulse registers, high for exactly one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= w_rise_next;
            r_fall <= w_fall_next;
        end
    end

    assign rise_o = r_rise;
    assign fall_o = r_fall;
`else
    assign rise_o = 1'b0;
    assign fall_o = 1'b0;
`endif

    assign level_o = r_level;
    assign busy_o  = (r_state == StWaitHigh) || (r_state == StWaitLow);

endmodule
